ysyx_22040088_lsu: RTL and testbench
====================================

// Module: ysyx_22040088_lsu
// PURPOSE
//  Load/store unit: the memory-side consumer of the decoder's mem_ena/mem_wen/mem_mask
//  controls. Accepts one access from the execute stage, runs it on a 64-bit
//  valid/ready data bus with byte strobes, and returns sign/zero-extended load data.
//  Each access is checked for alignment. A watchdog counter bounds each access.
//  Only one access is in flight at a time. The core stalls on req_ready=0.
// PARAMETERS
//  TIMEOUT  256  bus cycles allowed from entry to BUS until the response; 0 disables the watchdog
// PORTS
//  clk            in   1   clock; all state updates on the rising edge
//  rst_n          in   1   asynchronous reset, active-low
//  req_valid      in   1   access request (mem_ena)
//  req_ready      out  1   LSU can accept a request
//  req_wen        in   1   1=store, 0=load (mem_wen)
//  req_mask       in   4   one-hot size: 0001=D, 0010=W, 0100=H, 1000=B (mem_mask)
//  req_unsigned   in   1   zero-extend load (lwu/lhu/lbu); ignored for D and for stores
//  req_addr       in   64  byte address
//  req_wdata      in   64  store data, LSB-aligned
//  resp_valid     out  1   one-cycle completion pulse
//  resp_rdata     out  64  extended load data; 0 for stores and errors
//  resp_err       out  1   qualified by resp_valid: misaligned, bad mask, or timeout
//  bus_valid      out  1   bus request
//  bus_ready      in   1   bus accepts the request
//  bus_wen        out  1   write
//  bus_addr       out  64  {req_addr[63:3],3'b000}
//  bus_wdata      out  64  lane-replicated store data
//  bus_wstrb      out  8   byte enables; 0 for reads
//  bus_rvalid     in   1   read data valid
//  bus_rdata      in   64  read data, whole doubleword
// BEHAVIOUR
//  States: IDLE, BUS, WAIT, RESP. Reset (async) -> IDLE, counter=0. All registered
//   outputs reset to 0. req_ready=(state==IDLE), so req_ready reads 1 out of reset.
//  IDLE: when req_valid is high, latch all req_* signals. Compute the check:
//   - size error: req_mask not one-hot.
//   - alignment error: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0.
//   Error -> RESP with err=1, no bus activity. Otherwise -> BUS.
//  BUS: bus_valid=1 with addr/wen/wdata/wstrb held stable until bus_ready.
//   On the handshake: store -> RESP; load -> WAIT.
//  WAIT: on bus_rvalid, capture and extract the load result -> RESP.
//   bus_rvalid in any other state is ignored.
//  RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in BUS/WAIT/RESP.
//  Latency from accept cycle N: error resp at N+1. Store with bus_ready at N+1 -> resp N+2.
//   Load with bus_ready N+1, rvalid N+2 -> resp N+3.
//  Store lanes, with off=addr[2:0]:
//   - B: wdata={8{d[7:0]}}, wstrb=8'h01<<off.
//   - H: {4{d[15:0]}}, 8'h03<<off.
//   - W: {2{d[31:0]}}, 8'h0F<<off.
//   - D: d, 8'hFF.
//  Load: sh=bus_rdata>>(off*8). Take the low 8/16/32/64 bits.
//   Sign-extend, unless req_unsigned for B/H/W, which zero-extends.
//  Watchdog: counter clears on entry to BUS and increments each cycle in BUS/WAIT.
//   If TIMEOUT!=0 and count reaches TIMEOUT-1 with no completion -> RESP with err=1.
//   bus_valid drops at that point. A completion in the same cycle takes priority (no err).
//  rst_n low mid-access: abort immediately, all outputs 0, no resp pulse.
//   The bus side must tolerate the abandoned transaction.
// TESTING
//  lb addr=0x1003 unsigned=0, bus_rdata=0x0000_0000_8000_0000 -> wait 3 cycles,
//   resp_rdata=0xFFFF_FFFF_FFFF_FF80. Same access with unsigned=1 -> 0x80.
//  sh addr=0x1006 wdata=0xBEEF, bus_ready=1 -> bus_addr=0x1000, wstrb=0xC0,
//   wdata=0xBEEF_BEEF_BEEF_BEEF, resp_valid at accept+2, resp_rdata=0, err=0.
//  lw addr=0x1002 -> resp_valid at accept+1 with err=1, bus_valid never asserted.
//   Mask 0011 -> same result.
//  ld with bus_ready held 0 for 5 cycles, then rvalid 2 cycles later ->
//   bus signals stable throughout, exactly one resp_valid pulse, req_ready=0 until the pulse.
//  TIMEOUT=8, load with bus_rvalid never asserted -> resp_valid, err=1 at the 8th
//   BUS/WAIT cycle, back to IDLE.
//  rst_n pulsed low while in WAIT -> resp_valid/bus_valid drop to 0 at once;
//   a later bus_rvalid is ignored; the next request completes normally.

Source files
------------

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: runs one access at a time from the execute stage on a
// 64-bit valid/ready data bus with byte strobes and returns extended load data.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             access handshake (req_ready high only when idle)
//   req_wen, req_mask, req_unsigned store flag, one-hot size (D/W/H/B), zero-extend
//   req_addr, req_wdata             byte address, LSB-aligned store data
//   resp_valid, resp_rdata, resp_err one-cycle completion with load data / error flag
//   bus_valid/bus_ready             bus request handshake
//   bus_wen, bus_addr, bus_wdata, bus_wstrb  doubleword-aligned request payload
//   bus_rvalid, bus_rdata           read data return
module ysyx_22040088_lsu #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [3:0]  req_mask,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_wen,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wen;
  logic [3:0]         r_mask;
  logic               r_unsigned;
  logic [2:0]         r_off;

  logic               r_bus_valid;
  logic               r_bus_wen;
  logic [63:0]        r_bus_addr;
  logic [63:0]        r_bus_wdata;
  logic [7:0]         r_bus_wstrb;
  logic               r_resp_valid;
  logic [63:0]        r_resp_rdata;
  logic               r_resp_err;

  logic               w_req_bad;
  logic [63:0]        w_st_wdata;
  logic [7:0]         w_st_wstrb;
  logic [63:0]        w_ld_shift;
  logic [63:0]        w_ld_data;
  logic               w_timeout;
  logic               w_resp_err_nxt;
  logic [63:0]        w_resp_rdata_nxt;

  // Request check: size must be one-hot and the address naturally aligned.
  always_comb begin
    w_req_bad = 1'b0;
    case (req_mask)
      4'b0001: w_req_bad = |req_addr[2:0];
      4'b0010: w_req_bad = |req_addr[1:0];
      4'b0100: w_req_bad = req_addr[0];
      4'b1000: w_req_bad = 1'b0;
      default: w_req_bad = 1'b1;
    endcase
  end

  // Store lane replication and byte enables.
  always_comb begin
    w_st_wdata = req_wdata;
    w_st_wstrb = 8'hFF;
    case (req_mask)
      4'b1000: begin
        w_st_wdata = {8{req_wdata[7:0]}};
        w_st_wstrb = 8'h01 << req_addr[2:0];
      end
      4'b0100: begin
        w_st_wdata = {4{req_wdata[15:0]}};
        w_st_wstrb = 8'h03 << req_addr[2:0];
      end
      4'b0010: begin
        w_st_wdata = {2{req_wdata[31:0]}};
        w_st_wstrb = 8'h0F << req_addr[2:0];
      end
      default: begin
        w_st_wdata = req_wdata;
        w_st_wstrb = 8'hFF;
      end
    endcase
  end

  // Load extraction: bring the addressed bytes to bit 0, then extend.
  assign w_ld_shift = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = w_ld_shift;
    case (r_mask)
      4'b1000: w_ld_data = r_unsigned ? {56'd0, w_ld_shift[7:0]}
                                      : {{56{w_ld_shift[7]}}, w_ld_shift[7:0]};
      4'b0100: w_ld_data = r_unsigned ? {48'd0, w_ld_shift[15:0]}
                                      : {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
      4'b0010: w_ld_data = r_unsigned ? {32'd0, w_ld_shift[31:0]}
                                      : {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
      default: w_ld_data = w_ld_shift;
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && (r_cnt >= CNT_W'(TIMEOUT - 1));

  // Next-state and response value selection; a completing handshake beats the watchdog.
  always_comb begin
    w_state_nxt      = r_state;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = 64'd0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_bad) begin
            w_state_nxt    = S_RESP;
            w_resp_err_nxt = 1'b1;
          end else begin
            w_state_nxt = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (bus_ready) begin
          w_state_nxt = r_wen ? S_RESP : S_WAIT;
        end else if (w_timeout) begin
          w_state_nxt    = S_RESP;
          w_resp_err_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          w_state_nxt      = S_RESP;
          w_resp_rdata_nxt = w_ld_data;
        end else if (w_timeout) begin
          w_state_nxt    = S_RESP;
          w_resp_err_nxt = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Watchdog: zero while idle, so it reads 0 on the first bus cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == S_BUS) || (r_state == S_WAIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Request capture and bus payload, held for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen       <= 1'b0;
      r_mask      <= 4'd0;
      r_unsigned  <= 1'b0;
      r_off       <= 3'd0;
      r_bus_wen   <= 1'b0;
      r_bus_addr  <= 64'd0;
      r_bus_wdata <= 64'd0;
      r_bus_wstrb <= 8'd0;
    end else if ((r_state == S_IDLE) && req_valid) begin
      r_wen       <= req_wen;
      r_mask      <= req_mask;
      r_unsigned  <= req_unsigned;
      r_off       <= req_addr[2:0];
      r_bus_wen   <= req_wen;
      r_bus_addr  <= {req_addr[63:3], 3'b000};
      r_bus_wdata <= w_st_wdata;
      r_bus_wstrb <= req_wen ? w_st_wstrb : 8'd0;
    end
  end

  // Registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_valid  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 64'd0;
    end else begin
      r_bus_valid  <= (w_state_nxt == S_BUS);
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign bus_valid  = r_bus_valid;
  assign bus_wen    = r_bus_wen;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_wstrb  = r_bus_wstrb;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Testbench for ysyx_22040088_lsu: directed cases plus randomized accesses,
// checked every cycle against a transaction-level model of the LSU.
module tb_ysyx_22040088_lsu;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [3:0]  req_mask;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        bus_valid, bus_ready, bus_wen, bus_rvalid;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;

  always #5 clk = ~clk;

  ysyx_22040088_lsu #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_mask(req_mask), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cyc_i = -1;

  logic        exp_req_ready, exp_bus_valid, exp_resp_valid, exp_bus_wen, exp_err;
  logic [63:0] exp_bus_addr, exp_bus_wdata, exp_rdata;
  logic [7:0]  exp_bus_wstrb;

  int          got_lat;
  logic [63:0] got_rdata, got_addr, got_wdata;
  logic        got_err, saw_bus;
  logic [7:0]  got_wstrb;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [3:0] m);
    case (m)
      4'b0001: return 8;
      4'b0010: return 4;
      4'b0100: return 2;
      4'b1000: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_bad(input logic [3:0] m, input logic [63:0] a);
    int nb;
    nb = nbytes(m);
    if (nb == 0) return 1'b1;
    return (int'(a[2:0]) % nb) != 0;
  endfunction

  function automatic logic [7:0] m_wstrb(input logic [3:0] m, input logic [2:0] off);
    logic [15:0] s;
    s = ((16'd1 << nbytes(m)) - 16'd1) << off;
    return s[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [3:0] m, input logic [63:0] d);
    logic [63:0] w;
    int nb;
    nb = nbytes(m);
    w = '0;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = d[(b % nb)*8 +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [3:0] m, input logic uns,
                                         input logic [2:0] off, input logic [63:0] rd);
    logic [63:0] sh, v;
    int bits;
    logic fill;
    sh   = rd >> (int'(off) * 8);
    bits = nbytes(m) * 8;
    fill = (uns && bits != 64) ? 1'b0 : sh[bits-1];
    for (int i = 0; i < 64; i++) v[i] = (i < bits) ? sh[i] : fill;
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc_i == 0) begin
        saw_bus = 1'b0;
        got_lat = -1;
      end
      chk("req_ready", req_ready, exp_req_ready);
      chk("bus_valid", bus_valid, exp_bus_valid);
      chk("resp_valid", resp_valid, exp_resp_valid);
      if (exp_bus_valid) begin
        chk("bus_addr", bus_addr, exp_bus_addr);
        chk("bus_wen", bus_wen, exp_bus_wen);
        chk("bus_wstrb", bus_wstrb, exp_bus_wstrb);
        if (exp_bus_wen) chk("bus_wdata", bus_wdata, exp_bus_wdata);
      end
      if (exp_resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", resp_err, exp_err);
      end
      if (resp_valid) begin
        got_lat   = cyc_i;
        got_rdata = resp_rdata;
        got_err   = resp_err;
      end
      if (bus_valid) begin
        saw_bus   = 1'b1;
        got_addr  = bus_addr;
        got_wdata = bus_wdata;
        got_wstrb = bus_wstrb;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic noise();
    req_valid    = 1'b0;
    req_wen      = 1'($urandom);
    req_mask     = 4'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = {$urandom, $urandom};
    req_wdata    = {$urandom, $urandom};
    bus_ready    = 1'($urandom);
    bus_rvalid   = 1'($urandom);
    bus_rdata    = {$urandom, $urandom};
  endtask

  task automatic set_idle_exp();
    exp_req_ready  = 1'b1;
    exp_bus_valid  = 1'b0;
    exp_resp_valid = 1'b0;
  endtask

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
  // r = bus cycles with bus_ready low before the handshake, w = wait cycles before rvalid.
  task automatic run_tx(input logic wen, input logic [3:0] m, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input int r, input int w, input logic [63:0] rd);
    logic pre, terr;
    int nbus, nwait, n, lim, j, k;
    pre = is_bad(m, addr);
    terr = 1'b0;
    nbus = 0;
    nwait = 0;
    if (!pre) begin
      if (r > int'(T) - 1) begin
        nbus = T;
        terr = 1'b1;
      end else begin
        nbus = r + 1;
        if (!wen) begin
          j   = r + 1 + w;
          lim = (r + 1 > int'(T) - 1) ? r + 1 : int'(T) - 1;
          if (j <= lim) nwait = w + 1;
          else begin
            nwait = lim - r;
            terr  = 1'b1;
          end
        end
      end
    end
    n = nbus + nwait;

    noise();
    req_valid = 1'b1; req_wen = wen; req_mask = m; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    cyc_i = 0;
    set_idle_exp();
    exp_bus_addr  = {addr[63:3], 3'b000};
    exp_bus_wen   = wen;
    exp_bus_wstrb = wen ? m_wstrb(m, addr[2:0]) : 8'h00;
    exp_bus_wdata = m_wdata(m, wd);
    exp_err       = pre || terr;
    exp_rdata     = (pre || terr || wen) ? 64'd0 : m_load(m, uns, addr[2:0], rd);

    for (int i = 1; i <= n + 1; i++) begin
      @(posedge clk); #1;
      noise();
      cyc_i = i;
      k = i - 1;
      exp_req_ready = 1'b0;
      if (i <= n) begin
        exp_bus_valid  = (k < nbus);
        exp_resp_valid = 1'b0;
        if (k < nbus) bus_ready = (k == r);
        else begin
          bus_rvalid = (k == r + 1 + w);
          if (bus_rvalid) bus_rdata = rd;
        end
      end else begin
        exp_bus_valid  = 1'b0;
        exp_resp_valid = 1'b1;
      end
    end
    @(posedge clk); #1;
    noise();
    cyc_i = -1;
    set_idle_exp();
  endtask

  task automatic gap(input int c);
    repeat (c) begin
      @(posedge clk); #1;
      noise();
    end
  endtask

  initial begin
    logic [3:0] m;
    logic [63:0] a;
    rst_n = 1'b0;
    noise();
    set_idle_exp();
    #12;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_bus_wstrb", bus_wstrb, 8'd0);
    chk("rst_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    gap(2);

    // model pins
    chk("model_lb", m_load(4'b1000, 1'b0, 3'd3, 64'h0000_0000_8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
    chk("model_sh_strb", m_wstrb(4'b0100, 3'd6), 8'hC0);

    run_tx(1'b0, 4'b1000, 1'b0, 64'h1003, 64'd0, 0, 0, 64'h0000_0000_8000_0000);
    chk("lb_lat", got_lat, 3);
    chk("lb_data", got_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_err", got_err, 1'b0);
    run_tx(1'b0, 4'b1000, 1'b1, 64'h1003, 64'd0, 0, 0, 64'h0000_0000_8000_0000);
    chk("lbu_data", got_rdata, 64'h80);

    run_tx(1'b1, 4'b0100, 1'b0, 64'h1006, 64'hBEEF, 0, 0, 64'd0);
    chk("sh_lat", got_lat, 2);
    chk("sh_addr", got_addr, 64'h1000);
    chk("sh_wstrb", got_wstrb, 8'hC0);
    chk("sh_wdata", got_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    chk("sh_rdata", got_rdata, 64'd0);
    chk("sh_err", got_err, 1'b0);

    run_tx(1'b0, 4'b0010, 1'b0, 64'h1002, 64'd0, 0, 0, 64'd0);
    chk("lw_mis_lat", got_lat, 1);
    chk("lw_mis_err", got_err, 1'b1);
    chk("lw_mis_nobus", saw_bus, 1'b0);
    run_tx(1'b0, 4'b0011, 1'b0, 64'h1000, 64'd0, 0, 0, 64'd0);
    chk("badmask_lat", got_lat, 1);
    chk("badmask_err", got_err, 1'b1);
    chk("badmask_nobus", saw_bus, 1'b0);

    // stalled load finishing on the last allowed cycle
    run_tx(1'b0, 4'b0001, 1'b0, 64'h3000, 64'd0, 5, 1, 64'h0123_4567_89AB_CDEF);
    chk("ld_stall_lat", got_lat, 9);
    chk("ld_stall_data", got_rdata, 64'h0123_4567_89AB_CDEF);
    chk("ld_stall_err", got_err, 1'b0);

    run_tx(1'b0, 4'b0001, 1'b0, 64'h3008, 64'd0, 0, 50, 64'd0);
    chk("tmo_lat", got_lat, 9);
    chk("tmo_err", got_err, 1'b1);
    chk("tmo_rdata", got_rdata, 64'd0);
    gap(1);

    // reset while waiting for read data
    chk_en = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_mask = 4'b0001; req_addr = 64'h2000;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    chk("wait_req_ready", req_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", resp_valid, 1'b0);
    chk("arst_bus_valid", bus_valid, 1'b0);
    chk("arst_resp_err", resp_err, 1'b0);
    chk("arst_bus_addr", bus_addr, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_rvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_resp", resp_valid, 1'b0);
      chk("post_rst_ready", req_ready, 1'b1);
      @(posedge clk); #1;
    end
    noise();
    set_idle_exp();
    cyc_i = -1;
    chk_en = 1'b1;
    run_tx(1'b0, 4'b0010, 1'b1, 64'h4004, 64'd0, 0, 0, 64'hDEAD_BEEF_0000_0000);
    chk("post_rst_lat", got_lat, 3);
    chk("post_rst_data", got_rdata, 64'h0000_0000_DEAD_BEEF);

    // randomized accesses
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(7) == 0) m = 4'($urandom);
      else m = 4'b0001 << $urandom_range(3);
      a = {$urandom, $urandom};
      if ($urandom_range(1) == 1 && nbytes(m) != 0)
        a[2:0] = 3'(($urandom_range(7) / nbytes(m)) * nbytes(m));
      run_tx(1'($urandom), m, 1'($urandom), a, {$urandom, $urandom},
             $urandom_range(10), $urandom_range(10), {$urandom, $urandom});
      gap($urandom_range(2));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
